spi_tx: RTL and testbench

SPI_TX -- requirements
Module: spi_tx

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_sclk_gen.sv | 52 +++++
 rtl/spi_tx.sv | 123 ++++++++++++
 tb/tb_spi_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmitter FSM states and the bus mode this block implements.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_e;

    // Mode 1: SCLK idles low, MOSI launched on the rising edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b1;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: while enabled, SCLK toggles every HALF_PERIOD cycles starting from the idle level.
// rise_o/fall_o are asserted in the cycle before the SCLK register changes.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    always_comb begin
        tick   = en_i && (cnt_q == CNT_LAST);
        rise_o = tick && !sclk_q;
        fall_o = tick && sclk_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = CPOL;
        end else if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            sclk_q <= CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_tx.sv
// SPI master transmitter (mode 1, MSB first): CS setup, WIDTH SCLK periods, CS hold, done pulse.
module spi_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 4,
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             tx_start_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             tx_busy_o,
    output logic             tx_done_o,
    output logic             SCLK_o,
    output logic             MOSI_o,
    output logic             CS_n_o
);

    localparam int BW   = $clog2(WIDTH) + 1;
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);

    spi_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             sclk_rise, sclk_fall, launch_evt;

    spi_sclk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_sclk (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .en_i    (state_q == SHIFT),
        .sclk_o  (SCLK_o),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    assign launch_evt = CPHA ? sclk_rise : sclk_fall;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        tmr_d   = tmr_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                mosi_d = 1'b0;
                if (tx_start_i) begin
                    state_d = SETUP;
                    shreg_d = tx_data_i;
                    bit_d   = '0;
                    tmr_d   = '0;
                end
            end
            SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_d = SHIFT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            SHIFT: begin
                if (launch_evt) begin
                    mosi_d  = shreg_q[WIDTH-1];
                    shreg_d = shreg_q << 1;
                end
                // The WIDTH-th falling edge ends the frame; SCLK is already low entering HOLD
                if (sclk_fall) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        tmr_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            tmr_q   <= '0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            tmr_q   <= tmr_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign tx_busy_o = (state_q != IDLE);
    assign CS_n_o    = (state_q == IDLE);
    assign MOSI_o    = mosi_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx (WIDTH=8, HALF_PERIOD=2, CS_SETUP=2, CS_HOLD=2) plus a random-frame timing scoreboard.
module tb_spi_tx;

    localparam int W  = 8;
    localparam int HP = 2;
    localparam int SU = 2;
    localparam int HO = 2;

    logic         clock_i    = 1'b0;
    logic         reset_i    = 1'b0;
    logic         tx_start_i = 1'b0;
    logic [W-1:0] tx_data_i  = '0;
    logic         tx_busy_o, tx_done_o, SCLK_o, MOSI_o, CS_n_o;

    spi_tx #(.WIDTH(W), .HALF_PERIOD(HP), .CS_SETUP(SU), .CS_HOLD(HO)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .tx_start_i (tx_start_i),
        .tx_data_i  (tx_data_i),
        .tx_busy_o  (tx_busy_o),
        .tx_done_o  (tx_done_o),
        .SCLK_o     (SCLK_o),
        .MOSI_o     (MOSI_o),
        .CS_n_o     (CS_n_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    // Observations of one frame, indexed in cycles after the accepted start (n=1 is the first SETUP cycle)
    logic [7:0] w_bits;
    int w_nr, w_nf, w_lat, w_csfall, w_csrise, w_firstrise, w_lastfall;
    logic w_mosi_last, w_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] d, input bit keep);
        tx_data_i  = d;
        tx_start_i = 1'b1;
        @(negedge clock_i);
        if (!keep) tx_start_i = 1'b0;
    endtask

    task automatic watch(input int inject_at, input logic [7:0] inj_data, input int stop_nf);
        int n;
        logic sp, cp;
        w_bits = '0; w_nr = 0; w_nf = 0; w_lat = -1; w_csfall = -1; w_csrise = -1;
        w_firstrise = -1; w_lastfall = -1; w_mosi_last = 1'b0; w_timeout = 1'b0;
        sp = 1'b0; cp = 1'b1; n = 1;
        forever begin
            if (!CS_n_o && cp) w_csfall = n;
            if (CS_n_o && !cp) w_csrise = n;
            if (SCLK_o && !sp) begin
                w_nr++;
                if (w_nr == 1) w_firstrise = n;
            end
            if (!SCLK_o && sp) begin
                w_nf++;
                w_bits = {w_bits[6:0], MOSI_o};
                w_lastfall = n;
            end
            if (tx_done_o) begin
                w_lat = n;
                break;
            end
            if (stop_nf != 0 && w_nf == stop_nf) break;
            if (n >= 200) begin
                w_timeout = 1'b1;
                break;
            end
            w_mosi_last = MOSI_o;
            sp = SCLK_o;
            cp = CS_n_o;
            if (inject_at > 0 && n == inject_at) begin
                tx_start_i = 1'b1;
                tx_data_i  = inj_data;
            end else if (inject_at > 0 && n == inject_at + 1) begin
                tx_start_i = 1'b0;
            end
            @(negedge clock_i);
            n++;
        end
    endtask

    initial begin
        logic [7:0] d;
        // Reset state
        #1;
        chk("rst_cs", CS_n_o, 1);
        chk("rst_sclk", SCLK_o, 0);
        chk("rst_mosi", MOSI_o, 0);
        chk("rst_busy", tx_busy_o, 0);
        chk("rst_done", tx_done_o, 0);
        @(negedge clock_i);
        reset_i = 1'b1;
        @(negedge clock_i);

        // Single 0xA5 frame
        launch(8'hA5, 0);
        chk("a5_busy", tx_busy_o, 1);
        watch(0, 8'h00, 0);
        chk("a5_timeout", w_timeout, 0);
        chk("a5_bits", w_bits, 8'hA5);
        chk("a5_rises", w_nr, 8);
        chk("a5_falls", w_nf, 8);
        chk("a5_lat", w_lat, 37);
        chk("a5_hold_mosi", w_mosi_last, 1);
        chk("a5_done_cs", CS_n_o, 1);
        chk("a5_done_busy", tx_busy_o, 0);
        chk("a5_idle_mosi", MOSI_o, 0);
        @(negedge clock_i);
        chk("a5_done_pulse", tx_done_o, 0);

        // Back-to-back with start held high
        @(negedge clock_i);
        launch(8'h3C, 1);
        tx_data_i = 8'hC3;
        watch(0, 8'h00, 0);
        chk("b2b1_bits", w_bits, 8'h3C);
        chk("b2b1_lat", w_lat, 37);
        chk("b2b_gap_cs", CS_n_o, 1);
        @(negedge clock_i);
        tx_start_i = 1'b0;
        watch(0, 8'h00, 0);
        chk("b2b2_csfall", w_csfall, 1);
        chk("b2b2_bits", w_bits, 8'hC3);
        chk("b2b2_lat", w_lat, 37);
        @(negedge clock_i);

        // Start during SHIFT is ignored
        @(negedge clock_i);
        launch(8'hA5, 0);
        watch(10, 8'h00, 0);
        chk("ign_bits", w_bits, 8'hA5);
        chk("ign_lat", w_lat, 37);
        @(negedge clock_i);
        chk("ign_done_once", tx_done_o, 0);
        chk("ign_no_queue", tx_busy_o, 0);

        // Reset after the 4th falling edge, while SCLK is high again
        launch(8'h5A, 0);
        watch(0, 8'h00, 4);
        chk("rstm_falls", w_nf, 4);
        repeat (HP) @(negedge clock_i);
        chk("rstm_sclk_hi", SCLK_o, 1);
        reset_i = 1'b0;
        #1;
        chk("rstm_cs", CS_n_o, 1);
        chk("rstm_sclk", SCLK_o, 0);
        chk("rstm_mosi", MOSI_o, 0);
        chk("rstm_busy", tx_busy_o, 0);
        chk("rstm_done", tx_done_o, 0);
        repeat (2) @(negedge clock_i);
        reset_i = 1'b1;
        launch(8'hFF, 0);
        chk("rstm_accept", tx_busy_o, 1);
        watch(0, 8'h00, 0);
        chk("ff_bits", w_bits, 8'hFF);
        chk("ff_lat", w_lat, 37);

        // Random frames: CS setup/hold spacing relative to SCLK edges
        for (int f = 0; f < 100; f++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clock_i);
            launch(d, 0);
            watch(0, 8'h00, 0);
            chk("sb_timeout", w_timeout, 0);
            chk("sb_bits", w_bits, d);
            chk("sb_setup", w_firstrise - w_csfall, SU + HP);
            chk("sb_hold", w_csrise - w_lastfall, HO);
            chk("sb_lat", w_lat, 1 + SU + 2 * W * HP + HO);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
